// File: rtl/wb_downsizer_pkg.sv
// Shared types and helpers for the Wishbone width downsizer.
package wb_downsizer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BEAT = 3'd1,
        GAP  = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam int MAX_RATIO = 64;

    // Lowest beat index above cur whose byte-select slice is nonzero; returns ratio when none is left.
    function automatic int next_beat(input logic [MAX_RATIO-1:0] nz, input int cur, input int ratio);
        int r;
        r = ratio;
        for (int b = MAX_RATIO - 1; b >= 0; b--) begin
            if (b < ratio && b > cur && nz[b]) r = b;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_width_downsizer.sv
// Wishbone classic-cycle downsizer: splits each wide slave access into big-endian narrow master beats.
//
// state | meaning
// IDLE  | waiting for a slave request; latches the request fields
// BEAT  | master strobe asserted for the current beat
// GAP   | one cycle with strobe low between beats, cycle kept high
// DONE  | one-cycle slave acknowledge with assembled read data
// ERR   | one-cycle slave error
module wb_width_downsizer
    import wb_downsizer_pkg::*;
#(
    parameter int SDW = 32,
    parameter int MDW = 16,
    parameter int SAW = 21,
    localparam int RATIO = SDW / MDW,
    localparam int BW = $clog2(RATIO),
    localparam int MAW = SAW + BW,
    localparam int SSW = SDW / 8,
    localparam int MSW = MDW / 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           s_cyc_i,
    input  logic           s_stb_i,
    input  logic           s_we_i,
    input  logic [SAW-1:0] s_adr_i,
    input  logic [SSW-1:0] s_sel_i,
    input  logic [SDW-1:0] s_dat_i,
    output logic [SDW-1:0] s_dat_o,
    output logic           s_ack_o,
    output logic           s_err_o,
    output logic           m_cyc_o,
    output logic           m_stb_o,
    output logic           m_we_o,
    output logic [MAW-1:0] m_adr_o,
    output logic [MSW-1:0] m_sel_o,
    output logic [MDW-1:0] m_dat_o,
    input  logic [MDW-1:0] m_dat_i,
    input  logic           m_ack_i,
    input  logic           m_err_i
);

    state_t         state_q;
    logic [BW-1:0]  beat_q;
    logic [SAW-1:0] adr_q;
    logic           we_q;
    logic [SSW-1:0] sel_q;
    logic [SDW-1:0] dat_q;
    logic [SDW-1:0] rd_q;

    logic [MAX_RATIO-1:0] nz_in;
    logic [MAX_RATIO-1:0] nz_q;
    int                   first_beat;
    int                   nxt_beat;

    always_comb begin
        nz_in = '0;
        nz_q  = '0;
        for (int b = 0; b < RATIO; b++) begin
            nz_in[b] = |s_sel_i[SSW-1-b*MSW -: MSW];
            nz_q[b]  = |sel_q[SSW-1-b*MSW -: MSW];
        end
        first_beat = next_beat(nz_in, -1, RATIO);
        nxt_beat   = next_beat(nz_q, int'(beat_q), RATIO);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            beat_q  <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            rd_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_cyc_i && s_stb_i) begin
                        adr_q <= s_adr_i;
                        we_q  <= s_we_i;
                        sel_q <= s_sel_i;
                        dat_q <= s_dat_i;
                        rd_q  <= '0;
                        if (s_sel_i == '0) begin
                            beat_q  <= '0;
                            state_q <= DONE;
                        end else begin
                            beat_q  <= BW'(first_beat);
                            state_q <= BEAT;
                        end
                    end
                end
                BEAT: begin
                    // A slave abort wins over anything the master returns this cycle.
                    if (!s_cyc_i) begin
                        state_q <= IDLE;
                    end else if (m_err_i) begin
                        state_q <= ERR;
                    end else if (m_ack_i) begin
                        if (!we_q) begin
                            for (int b = 0; b < RATIO; b++) begin
                                if (beat_q == BW'(b)) rd_q[SDW-1-b*MDW -: MDW] <= m_dat_i;
                            end
                        end
                        if (nxt_beat < RATIO) begin
                            beat_q  <= BW'(nxt_beat);
                            state_q <= GAP;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                GAP:     state_q <= s_cyc_i ? BEAT : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        m_sel_o = '0;
        m_dat_o = '0;
        for (int b = 0; b < RATIO; b++) begin
            if (beat_q == BW'(b)) begin
                m_sel_o = sel_q[SSW-1-b*MSW -: MSW];
                m_dat_o = dat_q[SDW-1-b*MDW -: MDW];
            end
        end
    end

    assign m_cyc_o = (state_q == BEAT) || (state_q == GAP);
    assign m_stb_o = (state_q == BEAT);
    assign m_we_o  = we_q;
    assign m_adr_o = {adr_q, beat_q};
    assign s_ack_o = (state_q == DONE);
    assign s_err_o = (state_q == ERR);
    assign s_dat_o = rd_q;

endmodule

// File: tb/tb_wb_width_downsizer.sv
// Directed bench for wb_width_downsizer: a 32->16 and a 64->16 instance, each behind a small registered-ack memory.
module tb_wb_width_downsizer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // 32->16 instance
    logic        a_s_cyc = 0, a_s_stb = 0, a_s_we = 0;
    logic [20:0] a_s_adr = '0;
    logic [3:0]  a_s_sel = '0;
    logic [31:0] a_s_dat_w = '0, a_s_dat_r;
    logic        a_s_ack, a_s_err;
    logic        a_m_cyc, a_m_stb, a_m_we;
    logic [21:0] a_m_adr;
    logic [1:0]  a_m_sel;
    logic [15:0] a_m_dat_w, a_m_dat_r;
    logic        a_m_ack, a_m_err;

    // 64->16 instance
    logic        b_s_cyc = 0, b_s_stb = 0, b_s_we = 0;
    logic [20:0] b_s_adr = '0;
    logic [7:0]  b_s_sel = '0;
    logic [63:0] b_s_dat_w = '0, b_s_dat_r;
    logic        b_s_ack, b_s_err;
    logic        b_m_cyc, b_m_stb, b_m_we;
    logic [22:0] b_m_adr;
    logic [1:0]  b_m_sel;
    logic [15:0] b_m_dat_w, b_m_dat_r;
    logic        b_m_ack, b_m_err;

    wb_width_downsizer #(.SDW(32), .MDW(16), .SAW(21)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .s_cyc_i(a_s_cyc), .s_stb_i(a_s_stb), .s_we_i(a_s_we), .s_adr_i(a_s_adr),
        .s_sel_i(a_s_sel), .s_dat_i(a_s_dat_w), .s_dat_o(a_s_dat_r), .s_ack_o(a_s_ack), .s_err_o(a_s_err),
        .m_cyc_o(a_m_cyc), .m_stb_o(a_m_stb), .m_we_o(a_m_we), .m_adr_o(a_m_adr), .m_sel_o(a_m_sel),
        .m_dat_o(a_m_dat_w), .m_dat_i(a_m_dat_r), .m_ack_i(a_m_ack), .m_err_i(a_m_err)
    );

    wb_width_downsizer #(.SDW(64), .MDW(16), .SAW(21)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .s_cyc_i(b_s_cyc), .s_stb_i(b_s_stb), .s_we_i(b_s_we), .s_adr_i(b_s_adr),
        .s_sel_i(b_s_sel), .s_dat_i(b_s_dat_w), .s_dat_o(b_s_dat_r), .s_ack_o(b_s_ack), .s_err_o(b_s_err),
        .m_cyc_o(b_m_cyc), .m_stb_o(b_m_stb), .m_we_o(b_m_we), .m_adr_o(b_m_adr), .m_sel_o(b_m_sel),
        .m_dat_o(b_m_dat_w), .m_dat_i(b_m_dat_r), .m_ack_i(b_m_ack), .m_err_i(b_m_err)
    );

    // Memories: one wait state, ack (or injected err) registered the cycle after the strobe is seen.
    logic [15:0] mem_a [4];
    logic [15:0] mem_b [4];
    logic        err_en_a = 1'b0;
    logic [1:0]  err_idx_a = 2'd0;

    assign a_m_dat_r = mem_a[a_m_adr[1:0]];
    assign b_m_dat_r = mem_b[b_m_adr[1:0]];

    always @(posedge clk) begin
        a_m_ack <= 1'b0;
        a_m_err <= 1'b0;
        if (!rst_n) begin
            mem_a[0] <= 16'hDEAD; mem_a[1] <= 16'hBEEF; mem_a[2] <= 16'h0000; mem_a[3] <= 16'h0000;
        end else if (a_m_cyc && a_m_stb && !a_m_ack && !a_m_err) begin
            if (err_en_a && a_m_adr[1:0] == err_idx_a) begin
                a_m_err <= 1'b1;
            end else begin
                a_m_ack <= 1'b1;
                if (a_m_we && a_m_sel[1]) mem_a[a_m_adr[1:0]][15:8] <= a_m_dat_w[15:8];
                if (a_m_we && a_m_sel[0]) mem_a[a_m_adr[1:0]][7:0]  <= a_m_dat_w[7:0];
            end
        end
    end

    always @(posedge clk) begin
        b_m_ack <= 1'b0;
        b_m_err <= 1'b0;
        if (!rst_n) begin
            mem_b[0] <= 16'h1111; mem_b[1] <= 16'h2222; mem_b[2] <= 16'h3333; mem_b[3] <= 16'h4444;
        end else if (b_m_cyc && b_m_stb && !b_m_ack) begin
            b_m_ack <= 1'b1;
            if (b_m_we && b_m_sel[1]) mem_b[b_m_adr[1:0]][15:8] <= b_m_dat_w[15:8];
            if (b_m_we && b_m_sel[0]) mem_b[b_m_adr[1:0]][7:0]  <= b_m_dat_w[7:0];
        end
    end

    // Per-transaction observations
    int          r_ack_n, r_err_n, r_mack_n, r_beats, r_gaps;
    logic        r_cyc_seen, r_cyc_end;
    logic [63:0] r_rdat;
    logic [22:0] r_adr [4];
    logic [1:0]  r_sel [4];
    logic [15:0] r_dat [4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        r_ack_n = 0; r_err_n = 0; r_mack_n = 0; r_beats = 0; r_gaps = 0;
        r_cyc_seen = 0; r_cyc_end = 0; r_rdat = '0;
        for (int i = 0; i < 4; i++) begin
            r_adr[i] = '0; r_sel[i] = '0; r_dat[i] = '0;
        end
    endtask

    // Request fields are scrambled after the first cycle to show they are latched.
    task automatic run_a(input logic we, input logic [20:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        logic prev_stb, fin;
        prev_stb = 1'b0; fin = 1'b0;
        clear_obs();
        a_s_we = we; a_s_adr = adr; a_s_sel = sel; a_s_dat_w = dat; a_s_cyc = 1; a_s_stb = 1;
        for (int n = 1; n <= 40 && !fin; n++) begin
            step();
            if (n == 1) begin
                a_s_we = ~we; a_s_adr = ~adr; a_s_sel = ~sel; a_s_dat_w = ~dat;
            end
            if (a_m_cyc) r_cyc_seen = 1;
            if (a_m_cyc && !a_m_stb) r_gaps++;
            if (a_m_stb && !prev_stb && r_beats < 4) begin
                r_adr[r_beats] = 23'(a_m_adr); r_sel[r_beats] = a_m_sel; r_dat[r_beats] = a_m_dat_w;
                r_beats++;
            end
            prev_stb = a_m_stb;
            if (a_m_ack) r_mack_n = n;
            if (a_s_ack || a_s_err) begin
                if (a_s_ack) r_ack_n = n;
                if (a_s_err) r_err_n = n;
                r_rdat = 64'(a_s_dat_r);
                r_cyc_end = a_m_cyc;
                fin = 1'b1;
                a_s_cyc = 0; a_s_stb = 0;
            end
        end
        a_s_cyc = 0; a_s_stb = 0;
    endtask

    task automatic run_b(input logic we, input logic [20:0] adr, input logic [7:0] sel, input logic [63:0] dat);
        logic prev_stb, fin;
        prev_stb = 1'b0; fin = 1'b0;
        clear_obs();
        b_s_we = we; b_s_adr = adr; b_s_sel = sel; b_s_dat_w = dat; b_s_cyc = 1; b_s_stb = 1;
        for (int n = 1; n <= 40 && !fin; n++) begin
            step();
            if (n == 1) begin
                b_s_we = ~we; b_s_adr = ~adr; b_s_sel = ~sel; b_s_dat_w = ~dat;
            end
            if (b_m_cyc) r_cyc_seen = 1;
            if (b_m_cyc && !b_m_stb) r_gaps++;
            if (b_m_stb && !prev_stb && r_beats < 4) begin
                r_adr[r_beats] = b_m_adr; r_sel[r_beats] = b_m_sel; r_dat[r_beats] = b_m_dat_w;
                r_beats++;
            end
            prev_stb = b_m_stb;
            if (b_m_ack) r_mack_n = n;
            if (b_s_ack || b_s_err) begin
                if (b_s_ack) r_ack_n = n;
                if (b_s_err) r_err_n = n;
                r_rdat = b_s_dat_r;
                r_cyc_end = b_m_cyc;
                fin = 1'b1;
                b_s_cyc = 0; b_s_stb = 0;
            end
        end
        b_s_cyc = 0; b_s_stb = 0;
    endtask

    initial begin
        logic found;

        // Reset values
        step(); step();
        check("rst_a_slave", {a_s_ack, a_s_err, a_s_dat_r}, '0);
        check("rst_a_master", {a_m_cyc, a_m_stb, a_m_we, a_m_adr, a_m_sel, a_m_dat_w}, '0);
        check("rst_b_slave", {b_s_ack, b_s_err}, '0);
        check("rst_b_master", {b_m_cyc, b_m_stb, b_m_we, b_m_adr, b_m_sel, b_m_dat_w}, '0);
        check("rst_b_sdat", b_s_dat_r, '0);
        rst_n = 1'b1;
        step();

        // 1: full read, two beats with a gap
        run_a(1'b0, 21'h1234, 4'b1111, 32'h0);
        check("t1_ack_cycle", r_ack_n, 6);
        check("t1_err", r_err_n, 0);
        check("t1_rdat", r_rdat, 64'hDEADBEEF);
        check("t1_beats", r_beats, 2);
        check("t1_adr0", r_adr[0], 23'h2468);
        check("t1_adr1", r_adr[1], 23'h2469);
        check("t1_sel", {r_sel[0], r_sel[1]}, 4'b1111);
        check("t1_gaps", r_gaps, 1);
        step();
        check("t1_ack_one_cycle", a_s_ack, 1'b0);

        // 2: write touching the low lane only
        run_a(1'b1, 21'h0010, 4'b0011, 32'hAABBCCDD);
        check("t2_beats", r_beats, 2'd1);
        check("t2_adr", r_adr[0], 23'h21);
        check("t2_sel", r_sel[0], 2'b11);
        check("t2_dat", r_dat[0], 16'hCCDD);
        check("t2_gaps", r_gaps, 0);
        check("t2_ack_after_mack", r_ack_n - r_mack_n, 1);
        check("t2_ack_cycle", r_ack_n, 3);
        check("t2_mem", mem_a[1], 16'hCCDD);
        step();

        // High lane only: last beat is beat 0, skipped lane reads as zero
        run_a(1'b0, 21'h0000, 4'b1100, 32'h0);
        check("thi_beats", r_beats, 1);
        check("thi_adr", r_adr[0], 23'h0);
        check("thi_rdat", r_rdat, 64'hDEAD0000);
        check("thi_ack_cycle", r_ack_n, 3);
        step();

        // 3: 64->16 sparse read, beats 0 and 2
        run_b(1'b0, 21'h0, 8'hCC, 64'h0);
        check("t3_beats", r_beats, 2);
        check("t3_adr0", r_adr[0], 23'h0);
        check("t3_adr1", r_adr[1], 23'h2);
        check("t3_gaps", r_gaps, 1);
        check("t3_rdat", r_rdat, 64'h1111_0000_3333_0000);
        check("t3_ack_cycle", r_ack_n, 6);
        step();

        // 64->16 single-beat write on lane 1
        run_b(1'b1, 21'h1, 8'h30, 64'h0123_4567_89AB_CDEF);
        check("t3w_beats", r_beats, 1);
        check("t3w_adr", r_adr[0], 23'h5);
        check("t3w_dat", r_dat[0], 16'h4567);
        check("t3w_mem", mem_b[1], 16'h4567);
        check("t3w_ack_cycle", r_ack_n, 3);
        step();

        // 4: no byte selects
        run_a(1'b0, 21'h0042, 4'b0000, 32'h0);
        check("t4_cyc_seen", r_cyc_seen, 1'b0);
        check("t4_ack_cycle", r_ack_n, 1);
        check("t4_rdat", r_rdat, 64'h0);
        step();
        check("t4_ack_one_cycle", a_s_ack, 1'b0);

        // 5: master error on beat 1
        err_en_a = 1'b1; err_idx_a = 2'd1;
        run_a(1'b0, 21'h1234, 4'b1111, 32'h0);
        check("t5_err_cycle", r_err_n, 6);
        check("t5_no_ack", r_ack_n, 0);
        check("t5_cyc_low", r_cyc_end, 1'b0);
        step();
        check("t5_err_one_cycle", {a_s_err, a_s_ack}, 2'b00);
        err_en_a = 1'b0;

        // 6a: reset in BEAT
        a_s_we = 1; a_s_adr = 21'h1234; a_s_sel = 4'hF; a_s_dat_w = 32'h5A5A_A5A5; a_s_cyc = 1; a_s_stb = 1;
        step();
        check("t6a_in_beat", {a_m_cyc, a_m_stb, a_m_we}, 3'b111);
        #1 rst_n = 1'b0;
        #1;
        check("t6a_rst_slave", {a_s_ack, a_s_err, a_s_dat_r}, '0);
        check("t6a_rst_master", {a_m_cyc, a_m_stb, a_m_we, a_m_adr, a_m_sel, a_m_dat_w}, '0);
        a_s_cyc = 0; a_s_stb = 0; a_s_we = 0;
        step(); step();
        rst_n = 1'b1;
        step();

        // 6b: slave drops cycle during GAP
        a_s_we = 0; a_s_adr = 21'h1234; a_s_sel = 4'hF; a_s_cyc = 1; a_s_stb = 1;
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            step();
            if (a_m_cyc && !a_m_stb) found = 1'b1;
        end
        check("t6b_gap_reached", found, 1'b1);
        a_s_cyc = 0; a_s_stb = 0;
        step();
        check("t6b_cyc_dropped", {a_m_cyc, a_m_stb}, 2'b00);
        check("t6b_no_ack", {a_s_ack, a_s_err}, 2'b00);
        step();
        check("t6b_still_idle", {a_s_ack, a_s_err, a_m_cyc}, 3'b000);

        // Slave drops cycle in BEAT in the same cycle as the master ack
        a_s_we = 0; a_s_adr = 21'h0000; a_s_sel = 4'hF; a_s_cyc = 1; a_s_stb = 1;
        step(); step();
        check("tab_ack_pending", {a_m_stb, a_m_ack}, 2'b11);
        a_s_cyc = 0; a_s_stb = 0;
        step();
        check("tab_cyc_dropped", a_m_cyc, 1'b0);
        check("tab_no_ack", {a_s_ack, a_s_err}, 2'b00);
        check("tab_ack_discarded", a_s_dat_r, 32'h0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
